rv_top_level: RTL and testbench

- Board-level top of a single-cycle RV32I-subset computer. Contains the PC, a 64-word instruction memory, a 32x32 register file, the ALU/branch unit, a 64-word data memory and memory-mapped I/O.
- Program output is shown on LEDR and HEX0-5.
- Internal bench-access nets allow the instruction and data memories to be preloaded hierarchically.

---
 rtl/rv_top_level.sv | 191 +++++++++++++++++++
 tb/tb_rv_top_level.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rv_top_level.sv
// Single-cycle RV32I-subset board top: PC, 64-word imem/dmem, 32x32 regfile, MMIO at 0xF8/0xFC.
// Build option: define HEX_DISPLAY_EN to drive HEX0-5 from datapath_output; otherwise they are blank.
module rv_top_level #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic [7:0] VGA_X,
  output logic [7:0] VGA_Y,
  output logic [2:0] VGA_COLOUR,
  output logic       VGA_PLOT,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_CLK
);
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LW = 7'h03, OP_SW = 7'h23;
  localparam logic [6:0] OP_LUI = 7'h37, OP_BR = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67;

  logic [7:0]  r_pc;
  logic [31:0] r_out;
  logic        r_test_write;
  logic [31:0] r_regs [32];
  logic [31:0] r_imem [64];
  logic [31:0] r_dmem [64];

  // Bench-visible nets, kept as plain continuous drivers so they can be forced.
  logic [7:0]  program_counter;
  logic        test_write;
  logic [31:0] dummy_instr_writedata;
  logic        write_d_mem;
  logic [7:0]  address_d_mem;
  logic [31:0] d_mem_writedata;
  logic [31:0] datapath_output;

  logic [31:0] w_instr, w_rs1v, w_rs2v, w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  logic [31:0] w_alu_b, w_alu, w_addr_sum, w_load, w_rd_data;
  logic [6:0]  w_op;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_f3;
  logic [7:0]  w_pc4, w_next_pc;
  logic        w_rd_we, w_taken, w_io_sw, w_io_out, w_unused;

  assign program_counter       = r_pc;
  assign test_write            = r_test_write;
  assign datapath_output       = r_out;
  assign dummy_instr_writedata = 32'h0000_0000;

  assign w_instr = r_imem[program_counter[7:2]];
  assign w_op    = w_instr[6:0];
  assign w_rd    = w_instr[11:7];
  assign w_f3    = w_instr[14:12];
  assign w_rs1   = w_instr[19:15];
  assign w_rs2   = w_instr[24:20];
  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'h000};
  assign w_rs1v  = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1];
  assign w_rs2v  = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2];

  // Loads, stores and JALR share one rs1+imm adder.
  assign w_addr_sum      = w_rs1v + ((w_op == OP_SW) ? w_imm_s : w_imm_i);
  assign address_d_mem   = w_addr_sum[7:0];
  assign write_d_mem     = (w_op == OP_SW) && !test_write;
  assign d_mem_writedata = w_rs2v;
  assign w_io_sw         = (address_d_mem[7:2] == 6'h3E);
  assign w_io_out        = (address_d_mem[7:2] == 6'h3F);
  assign w_load = w_io_sw  ? {22'h0, SW} :
                  w_io_out ? datapath_output : r_dmem[address_d_mem[7:2]];

  always_comb begin
    w_alu_b = (w_op == OP_R) ? w_rs2v : w_imm_i;
    case (w_f3)
      3'b000:  w_alu = (w_op == OP_R && w_instr[30]) ? w_rs1v - w_alu_b : w_rs1v + w_alu_b;
      3'b001:  w_alu = w_rs1v << w_alu_b[4:0];
      3'b010:  w_alu = {31'h0, $signed(w_rs1v) < $signed(w_alu_b)};
      3'b100:  w_alu = w_rs1v ^ w_alu_b;
      3'b101:  w_alu = w_instr[30] ? $unsigned($signed(w_rs1v) >>> w_alu_b[4:0]) : w_rs1v >> w_alu_b[4:0];
      3'b110:  w_alu = w_rs1v | w_alu_b;
      3'b111:  w_alu = w_rs1v & w_alu_b;
      default: w_alu = 32'h0;
    endcase
  end

  always_comb begin
    case (w_f3)
      3'b000:  w_taken = (w_rs1v == w_rs2v);
      3'b001:  w_taken = (w_rs1v != w_rs2v);
      3'b100:  w_taken = ($signed(w_rs1v) <  $signed(w_rs2v));
      3'b101:  w_taken = ($signed(w_rs1v) >= $signed(w_rs2v));
      default: w_taken = 1'b0;
    endcase
  end

  assign w_pc4 = program_counter + 8'd4;

  // Unknown opcodes fall through the default: PC+4, nothing written.
  always_comb begin
    w_next_pc = w_pc4;
    w_rd_we   = 1'b0;
    w_rd_data = 32'h0;
    case (w_op)
      OP_R, OP_I: begin w_rd_we = 1'b1; w_rd_data = w_alu; end
      OP_LW:      begin w_rd_we = 1'b1; w_rd_data = w_load; end
      OP_LUI:     begin w_rd_we = 1'b1; w_rd_data = w_imm_u; end
      OP_BR:      if (w_taken) w_next_pc = program_counter + w_imm_b[7:0];
      OP_JAL: begin
        w_rd_we = 1'b1; w_rd_data = {24'h0, w_pc4};
        w_next_pc = program_counter + w_imm_j[7:0];
      end
      OP_JALR: begin
        w_rd_we = 1'b1; w_rd_data = {24'h0, w_pc4};
        w_next_pc = w_addr_sum[7:0] & 8'hFE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY[3]) begin
      r_pc         <= RESET_PC;
      r_out        <= 32'h0;
      r_test_write <= 1'b0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
    end else begin
      if (!test_write) begin
        r_pc <= w_next_pc;
        if (w_rd_we && w_rd != 5'd0) r_regs[w_rd] <= w_rd_data;
      end
      if (write_d_mem && w_io_out) r_out <= d_mem_writedata;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (KEY[3]) begin
      if (test_write) r_imem[program_counter[7:2]] <= dummy_instr_writedata;
      if (write_d_mem && !w_io_out && !w_io_sw) r_dmem[address_d_mem[7:2]] <= d_mem_writedata;
    end
  end

  assign LEDR = datapath_output[9:0];

`ifdef HEX_DISPLAY_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction
  assign HEX0 = seg7(datapath_output[3:0]);
  assign HEX1 = seg7(datapath_output[7:4]);
  assign HEX2 = seg7(datapath_output[11:8]);
  assign HEX3 = seg7(datapath_output[15:12]);
  assign HEX4 = seg7(datapath_output[19:16]);
  assign HEX5 = seg7(datapath_output[23:20]);
`else
  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;
`endif

  assign VGA_R = 8'h0;
  assign VGA_G = 8'h0;
  assign VGA_B = 8'h0;
  assign VGA_X = 8'h0;
  assign VGA_Y = 8'h0;
  assign VGA_COLOUR = 3'h0;
  assign VGA_PLOT = 1'b0;
  assign VGA_HS = 1'b1;
  assign VGA_VS = 1'b1;
  assign VGA_CLK = 1'b0;

  assign w_unused = ^{KEY[2:0], w_imm_b[31:8], w_imm_j[31:8], w_addr_sum[31:8], address_d_mem[1:0]};
endmodule

// File: tb/tb_rv_top_level.sv
// Directed bench for rv_top_level: preloads a program through the test_write path, then
// steps it cycle by cycle checking PC, datapath_output, LEDR/HEX and a few internal registers.
module tb_rv_top_level;
  logic       CLOCK_50 = 1'b0;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [7:0] VGA_R, VGA_G, VGA_B, VGA_X, VGA_Y;
  logic [2:0] VGA_COLOUR;
  logic       VGA_PLOT, VGA_HS, VGA_VS, VGA_CLK;

  int ntests = 0;
  int nfail  = 0;
  logic [31:0] prog [64];
  logic [7:0]  tb_pc;
  logic [31:0] tb_word;
  logic [6:0]  hex_2, hex_0, hex_e;

  rv_top_level #(.RESET_PC(8'h00)) dut (
    .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
    .VGA_COLOUR(VGA_COLOUR), .VGA_PLOT(VGA_PLOT), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_CLK(VGA_CLK)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  initial begin
`ifdef HEX_DISPLAY_EN
    hex_2 = 7'h24; hex_0 = 7'h40; hex_e = 7'h06;
`else
    hex_2 = 7'h7F; hex_0 = 7'h7F; hex_e = 7'h7F;
`endif
    for (int i = 0; i < 64; i++) prog[i] = 32'h0000_0013;
    prog[0]  = e_i(12'd5,   5'd0, 3'b000, 5'd1, 7'h13);   // ADDI x1,x0,5
    prog[1]  = e_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'h13);   // ADDI x2,x0,-3
    prog[2]  = e_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);      // ADD x3,x1,x2
    prog[3]  = e_s(12'h0FC, 5'd3, 5'd0);                   // SW x3,0xFC(x0)
    prog[4]  = e_i(12'h055, 5'd0, 3'b000, 5'd6, 7'h13);
    prog[5]  = e_s(12'h010, 5'd6, 5'd0);
    prog[6]  = e_i(12'h010, 5'd0, 3'b010, 5'd7, 7'h03);   // LW x7,0x10(x0)
    prog[7]  = e_s(12'h0FC, 5'd7, 5'd0);
    prog[8]  = e_i(12'd0,   5'd0, 3'b000, 5'd4, 7'h13);
    prog[9]  = e_i(12'd10,  5'd0, 3'b000, 5'd8, 7'h13);
    prog[10] = e_i(12'd1,   5'd4, 3'b000, 5'd4, 7'h13);   // loop: ADDI x4,x4,1
    prog[11] = e_b(13'd8, 5'd8, 5'd4, 3'b000);             // BEQ x4,x8,+8
    prog[12] = e_j(21'h1FFFF8, 5'd0);                      // JAL x0,-8
    prog[13] = e_s(12'h0FC, 5'd4, 5'd0);
    prog[14] = e_i(12'h0F8, 5'd0, 3'b010, 5'd5, 7'h03);   // LW x5,0xF8(x0)
    prog[15] = e_s(12'h0FC, 5'd5, 5'd0);
    prog[16] = e_s(12'h0FC, 5'd0, 5'd0);
    prog[17] = e_i(12'd1,   5'd0, 3'b000, 5'd9, 7'h13);
    prog[18] = e_s(12'h0FC, 5'd9, 5'd0);
    prog[19] = e_i(12'd7,   5'd0, 3'b000, 5'd0, 7'h13);   // ADDI x0,x0,7
    prog[20] = e_s(12'h0FC, 5'd0, 5'd0);
    prog[21] = e_i(12'd99,  5'd0, 3'b000, 5'd1, 7'h0B);   // unsupported opcode
    prog[22] = e_s(12'h0FC, 5'd1, 5'd0);
    prog[23] = {20'h12345, 5'd10, 7'h37};                  // LUI x10,0x12345
    prog[24] = e_s(12'h0FC, 5'd10, 5'd0);
    prog[25] = e_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd11);     // SUB x11,x2,x1
    prog[26] = e_r(7'h20, 5'd1, 5'd11, 3'b101, 5'd12);    // SRA x12,x11,x1
    prog[27] = e_r(7'h00, 5'd1, 5'd11, 3'b010, 5'd13);    // SLT x13,x11,x1
    prog[28] = e_r(7'h00, 5'd13, 5'd12, 3'b100, 5'd14);   // XOR x14,x12,x13
    prog[29] = e_s(12'h0FC, 5'd14, 5'd0);
    prog[30] = e_i(12'h081, 5'd0, 3'b000, 5'd15, 7'h67);  // JALR x15,0x81(x0)
    prog[32] = e_j(21'h00007C, 5'd0);                      // JAL x0,+0x7C -> 0xFC
    prog[63] = e_j(21'd4, 5'd0);                           // JAL x0,+4 at 0xFC

    // Reset
    KEY = 4'b0111; SW = 10'b0110101011; tb_pc = 8'h00; tb_word = 32'h0;
    tick(1);
    chk("reset_pc", {24'h0, dut.program_counter}, 32'h0);
    chk("reset_out", dut.datapath_output, 32'h0);
    chk("reset_ledr", {22'h0, LEDR}, 32'h0);
    chk("vga_hs", {31'h0, VGA_HS}, 32'h1);

    // Preload imem with PC frozen
    KEY = 4'b1111;
    force dut.test_write = 1'b1;
    force dut.program_counter = tb_pc;
    force dut.dummy_instr_writedata = tb_word;
    for (int i = 0; i < 64; i++) begin
      tb_pc = 8'(i * 4);
      tb_word = prog[i];
      tick(1);
    end
    release dut.test_write;
    release dut.program_counter;
    release dut.dummy_instr_writedata;
    #1;
    chk("preload_pc_frozen", {24'h0, dut.program_counter}, 32'h0);
    chk("imem0", dut.r_imem[0], 32'h0050_0093);
    chk("imem11", dut.r_imem[11], 32'h0082_0463);
    chk("imem63", dut.r_imem[63], 32'h0040_006F);
    chk("preload_out", dut.datapath_output, 32'h0);

    // Run; checkpoints in edges since preload end
    tick(1); chk("pc_after_1", {24'h0, dut.program_counter}, 32'h04);
    tick(1); chk("pc_after_2", {24'h0, dut.program_counter}, 32'h08);
    tick(2);
    chk("arith_out", dut.datapath_output, 32'h2);
    chk("arith_ledr", {22'h0, LEDR}, 32'h2);
    chk("arith_hex0", {25'h0, HEX0}, {25'h0, hex_2});
    chk("arith_hex1", {25'h0, HEX1}, {25'h0, hex_0});
    tick(4);
    chk("lw_out", dut.datapath_output, 32'h55);
    chk("dmem4", dut.r_dmem[4], 32'h55);
    tick(31);
    chk("loop_pc39", {24'h0, dut.program_counter}, 32'h34);
    chk("loop_out39", dut.datapath_output, 32'h55);
    tick(1);
    chk("loop_out40", dut.datapath_output, 32'd10);
    chk("loop_pc40", {24'h0, dut.program_counter}, 32'h38);
    tick(2);
    chk("sw_ledr", {22'h0, LEDR}, 32'h1AB);
    chk("sw_out", dut.datapath_output, 32'h1AB);
    tick(1); chk("bit0_low", {31'h0, dut.datapath_output[0]}, 32'h0);
    tick(2); chk("bit0_high", {31'h0, dut.datapath_output[0]}, 32'h1);
    tick(2);
    chk("x0_out", dut.datapath_output, 32'h0);
    chk("x0_reg", dut.r_regs[0], 32'h0);
    tick(2); chk("nop_out", dut.datapath_output, 32'h5);
    tick(2); chk("lui_out", dut.datapath_output, 32'h1234_5000);
    tick(5);
    chk("alu_out", dut.datapath_output, 32'hFFFF_FFFE);
    chk("alu_hex0", {25'h0, HEX0}, {25'h0, hex_e});
    chk("pc_78", {24'h0, dut.program_counter}, 32'h78);
    tick(1);
    chk("jalr_pc", {24'h0, dut.program_counter}, 32'h80);
    chk("jalr_link", dut.r_regs[15], 32'h7C);
    tick(1); chk("jal_pc_fc", {24'h0, dut.program_counter}, 32'hFC);
    tick(1); chk("jal_wrap", {24'h0, dut.program_counter}, 32'h00);
    tick(3); chk("pc_before_rst", {24'h0, dut.program_counter}, 32'h0C);

    // Reset over an SW-to-0xFC instruction must win
    KEY = 4'b0111;
    tick(1);
    chk("midrst_pc", {24'h0, dut.program_counter}, 32'h0);
    chk("midrst_out", dut.datapath_output, 32'h0);
    chk("midrst_x1", dut.r_regs[1], 32'h0);
    KEY = 4'b1111;
    tick(1); chk("post_rst_pc", {24'h0, dut.program_counter}, 32'h04);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
